morse_key_sequencer: RTL and testbench

//  Timing controller for the 4-bit digit-to-Morse datapath. Accepts one BCD digit (0-9) per

---
 rtl/morse_key_sequencer_pkg.sv | 31 +++
 rtl/morse_digit_rom.sv | 28 ++
 rtl/morse_key_sequencer.sv | 127 ++++++++++++
 tb/tb_morse_key_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_key_sequencer_pkg.sv
// rtl/morse_key_sequencer_pkg.sv - shared state encodings and Morse digit patterns
package morse_key_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_CHAR_GAP
    } state_e;

    localparam int SYM_COUNT = 5;

    // bit4 is the first symbol sent; 1 = dash, 0 = dot
    localparam logic [4:0] PAT_0 = 5'b11111;
    localparam logic [4:0] PAT_1 = 5'b01111;
    localparam logic [4:0] PAT_2 = 5'b00111;
    localparam logic [4:0] PAT_3 = 5'b00011;
    localparam logic [4:0] PAT_4 = 5'b00001;
    localparam logic [4:0] PAT_5 = 5'b00000;
    localparam logic [4:0] PAT_6 = 5'b10000;
    localparam logic [4:0] PAT_7 = 5'b11000;
    localparam logic [4:0] PAT_8 = 5'b11100;
    localparam logic [4:0] PAT_9 = 5'b11110;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/morse_digit_rom.sv
// rtl/morse_digit_rom.sv - combinational BCD digit to 5-symbol Morse pattern lookup
module morse_digit_rom
    import morse_key_sequencer_pkg::*;
(
    input  logic [3:0] digit,
    output logic       valid,
    output logic [4:0] pattern
);

    always_comb begin
        valid   = 1'b1;
        pattern = '0;
        case (digit)
            4'd0: pattern = PAT_0;
            4'd1: pattern = PAT_1;
            4'd2: pattern = PAT_2;
            4'd3: pattern = PAT_3;
            4'd4: pattern = PAT_4;
            4'd5: pattern = PAT_5;
            4'd6: pattern = PAT_6;
            4'd7: pattern = PAT_7;
            4'd8: pattern = PAT_8;
            4'd9: pattern = PAT_9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_key_sequencer.sv
// rtl/morse_key_sequencer.sv - plays one accepted BCD digit out as a timed Morse key signal
module morse_key_sequencer
    import morse_key_sequencer_pkg::*;
#(
    parameter int UNIT_CYCLES    = 4,
    parameter int DASH_UNITS     = 3,
    parameter int SYM_GAP_UNITS  = 1,
    parameter int CHAR_GAP_UNITS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    output logic       digit_ready,
    output logic       key_out,
    output logic       busy,
    output logic [2:0] sym_idx,
    output logic       char_done,
    output logic       err_invalid
);

    localparam int MAX_UNITS = max3(DASH_UNITS, CHAR_GAP_UNITS, SYM_GAP_UNITS);
    localparam int CW        = $clog2(UNIT_CYCLES * MAX_UNITS + 1);

    localparam logic [CW-1:0] DOT_LD   = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] DASH_LD  = CW'(UNIT_CYCLES * DASH_UNITS - 1);
    localparam logic [CW-1:0] SPACE_LD = CW'(UNIT_CYCLES * SYM_GAP_UNITS - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(UNIT_CYCLES * CHAR_GAP_UNITS - 1);
    localparam logic [2:0]    LAST_IDX = 3'(SYM_COUNT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [4:0]    pat_q, pat_d;
    logic          key_q, key_d;
    logic          err_q, err_d;
    logic          rom_valid;
    logic [4:0]    rom_pattern;

    morse_digit_rom u_rom (
        .digit   (digit),
        .valid   (rom_valid),
        .pattern (rom_pattern)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pat_d   = pat_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (digit_valid) begin
                    if (rom_valid) begin
                        state_d = ST_MARK;
                        pat_d   = rom_pattern;
                        idx_d   = '0;
                        cnt_d   = rom_pattern[4] ? DASH_LD : DOT_LD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_MARK: begin
                if (cnt_q == '0) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_CHAR_GAP;
                        cnt_d   = GAP_LD;
                    end else begin
                        state_d = ST_SPACE;
                        cnt_d   = SPACE_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SPACE: begin
                if (cnt_q == '0) begin
                    // pat_q[3] is the symbol that becomes current after the shift
                    state_d = ST_MARK;
                    idx_d   = idx_q + 3'd1;
                    pat_d   = {pat_q[3:0], 1'b0};
                    cnt_d   = pat_q[3] ? DASH_LD : DOT_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CHAR_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        key_d = (state_d == ST_MARK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            pat_q   <= '0;
            key_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pat_q   <= pat_d;
            key_q   <= key_d;
            err_q   <= err_d;
        end
    end

    assign digit_ready = (state_q == ST_IDLE) && !reset;
    assign busy        = (state_q != ST_IDLE);
    assign key_out     = key_q;
    assign sym_idx     = idx_q;
    assign char_done   = (state_q == ST_CHAR_GAP) && (cnt_q == '0);
    assign err_invalid = err_q;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// tb/tb_morse_key_sequencer.sv - scoreboard bench with randomized digits and a behavioural Morse model
module tb_morse_key_sequencer;

    localparam int U = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       digit_valid;
    logic [3:0] digit;
    logic       digit_ready;
    logic       key_out;
    logic       busy;
    logic [2:0] sym_idx;
    logic       char_done;
    logic       err_invalid;

    morse_key_sequencer #(.UNIT_CYCLES(U)) dut (
        .clk         (clk),
        .reset       (reset),
        .digit_valid (digit_valid),
        .digit       (digit),
        .digit_ready (digit_ready),
        .key_out     (key_out),
        .busy        (busy),
        .sym_idx     (sym_idx),
        .char_done   (char_done),
        .err_invalid (err_invalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    string morse_tab [10] = '{"-----", ".----", "..---", "...--", "....-",
                              ".....", "-....", "--...", "---..", "----."};

    // Expected key trace for one digit, built from unit timing rules
    function automatic void model(input int d, output logic [63:0] tr, output int len);
        int ml;
        tr  = '0;
        len = 0;
        for (int s = 0; s < 5; s++) begin
            ml = (morse_tab[d][s] == "-") ? 3 * U : U;
            for (int i = 0; i < ml; i++) begin
                tr[len] = 1'b1;
                len++;
            end
            if (s < 4) len += U;
        end
        len += 3 * U;
    endfunction

    typedef struct {
        int digit;
        int acc;
        bit b2b;
    } exp_t;

    exp_t exp_q[$];
    int   err_exp[$];
    bit   mon_hold = 1'b0;

    // Monitor state
    exp_t        cur;
    bit          in_digit = 1'b0;
    bit          chk_ready_next = 1'b0;
    logic [63:0] rec;
    int          rlen;
    int          nmark;
    logic        prev_key;
    int          last_cd = -100;

    always @(negedge clk) begin
        logic [63:0] etr;
        int          elen;
        int          fixed_len;
        int          e;
        if (reset || mon_hold) begin
            in_digit       = 1'b0;
            chk_ready_next = 1'b0;
            exp_q.delete();
            err_exp.delete();
        end else begin
            if (err_invalid) begin
                if (err_exp.size() == 0) begin
                    check(1'b0, "err_unexpected", 1, 0);
                end else begin
                    e = err_exp.pop_front();
                    check(cyc == e + 1, "err_latency", cyc, e + 1);
                    check(!busy, "err_busy", busy, 0);
                end
            end
            if (chk_ready_next) begin
                check(digit_ready && !busy, "ready_after_char_done", {digit_ready, busy}, 2'b10);
                chk_ready_next = 1'b0;
            end
            if (in_digit && !busy) begin
                check(1'b0, "busy_dropped_early", rlen, 0);
                in_digit = 1'b0;
            end
            if (busy && !in_digit) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_busy", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check(cyc == cur.acc + 1, "accept_latency", cyc, cur.acc + 1);
                    if (cur.b2b)
                        check(cur.acc == last_cd + 1, "b2b_accept", cur.acc, last_cd + 1);
                    in_digit = 1'b1;
                    rec      = '0;
                    rlen     = 0;
                    nmark    = 0;
                    prev_key = 1'b0;
                end
            end
            if (in_digit) begin
                if (rlen < 64) rec[rlen] = key_out;
                rlen++;
                if (key_out && !prev_key) begin
                    check(sym_idx == 3'(nmark), "sym_idx_step", sym_idx, nmark);
                    nmark++;
                end
                prev_key = key_out;
                if (char_done) begin
                    model(cur.digit, etr, elen);
                    check(rlen == elen, "busy_len", rlen, elen);
                    check(rec == etr, "key_pattern", rec, etr);
                    check(nmark == 5, "mark_count", nmark, 5);
                    check(!key_out, "key_in_char_gap", key_out, 0);
                    fixed_len = (cur.digit == 0) ? 44 : (cur.digit == 1) ? 40 : (cur.digit == 5) ? 24 : -1;
                    if (fixed_len > 0)
                        check(rlen == fixed_len, "busy_len_fixed", rlen, fixed_len);
                    last_cd        = cyc;
                    in_digit       = 1'b0;
                    chk_ready_next = 1'b1;
                end
            end else if (!busy) begin
                check(!key_out && sym_idx == 3'd0 && !char_done, "idle_outputs",
                      {key_out, sym_idx, char_done}, 0);
            end
        end
    end

    task automatic send(input int d, input bit b2b, input bit hold);
        int   t;
        exp_t x;
        t = 0;
        @(negedge clk);
        digit       = 4'(d);
        digit_valid = 1'b1;
        while (!digit_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!digit_ready) begin
            check(1'b0, "accept_timeout", 0, 1);
            digit_valid = 1'b0;
            return;
        end
        x.digit = d;
        x.acc   = cyc;
        x.b2b   = b2b;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        if (!hold) begin
            digit_valid = 1'b0;
            digit       = 4'($urandom);
        end
    endtask

    task automatic offer_invalid(input int d);
        int t;
        t = 0;
        @(negedge clk);
        while (!digit_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!digit_ready) begin
            check(1'b0, "idle_timeout", 0, 1);
            return;
        end
        digit       = 4'(d);
        digit_valid = 1'b1;
        err_exp.push_back(cyc);
        @(posedge clk);
        #1;
        digit_valid = 1'b0;
    endtask

    initial begin
        int order[10];
        int t;
        int r;
        reset       = 1'b1;
        digit_valid = 1'b0;
        digit       = 4'd0;
        repeat (3) @(negedge clk);
        check(!key_out && !busy && sym_idx == 3'd0 && !char_done && !err_invalid,
              "reset_outputs", {key_out, busy, sym_idx, char_done, err_invalid}, 0);
        reset = 1'b0;
        @(negedge clk);
        check(digit_ready, "ready_after_reset", digit_ready, 1);

        send(1, 1'b0, 1'b0);
        send(5, 1'b0, 1'b0);
        send(0, 1'b0, 1'b0);
        offer_invalid(12);
        send(9, 1'b0, 1'b1);
        send(8, 1'b1, 1'b0);

        // Abort a digit mid-mark with reset
        send(3, 1'b0, 1'b0);
        t = 0;
        while (!key_out && t < 100) begin
            @(negedge clk);
            t++;
        end
        check(key_out, "reset_test_mark_seen", key_out, 1);
        mon_hold = 1'b1;
        reset    = 1'b1;
        #1;
        check(!key_out && !busy, "reset_abort", {key_out, busy}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check(digit_ready && !busy, "ready_after_abort", {digit_ready, busy}, 2'b10);
        mon_hold = 1'b0;

        // Sweep 0..9 in shuffled order with random valid gaps
        for (int i = 0; i < 10; i++) order[i] = i;
        for (int i = 9; i > 0; i--) begin
            r        = $urandom_range(0, i);
            t        = order[i];
            order[i] = order[r];
            order[r] = t;
        end
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send(order[i], 1'b0, 1'b0);
        end

        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(0, 15);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (r > 9) offer_invalid(r);
            else       send(r, 1'b0, 1'b0);
        end

        t = 0;
        while ((busy || exp_q.size() != 0 || in_digit) && t < 500) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check(exp_q.size() == 0 && !in_digit, "drain_digits", exp_q.size(), 0);
        check(err_exp.size() == 0, "drain_errors", err_exp.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
